// File: rtl/commit_trace_buffer_if.sv
// Bundle of the capture inputs and the trace output port of commit_trace_buffer.
// The output port is valid/ready: an entry transfers on a rising edge where out_valid and out_ready are both 1. While out_valid=1 and out_ready=0, the payload holds.
interface commit_trace_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int CNT_W  = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              reg_write_sig;
   logic [REG_W-1:0]  reg_num;
   logic [DATA_W-1:0] reg_data;
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              cfg_reg_en;
   logic              cfg_mem_en;
   logic              clear;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_kind;
   logic [ADDR_W-1:0] out_idx;
   logic [DATA_W-1:0] out_data;
   logic [TS_W-1:0]   out_ts;
   logic [LVL_W-1:0]  level;
   logic [CNT_W-1:0]  drop_cnt;
   logic              overflow;
   logic              conflict;

   modport master (
      output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
      output cfg_reg_en, cfg_mem_en, clear, out_ready,
      input  out_valid, out_kind, out_idx, out_data, out_ts, level, drop_cnt,
      input  overflow, conflict
   );

   modport slave (
      input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
      input  cfg_reg_en, cfg_mem_en, clear, out_ready,
      output out_valid, out_kind, out_idx, out_data, out_ts, level, drop_cnt,
      output overflow, conflict
   );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures up to two register/memory events per cycle with a timestamp.
// It counts the events that a full buffer drops.
module commit_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int CNT_W  = 8
) (
   input logic                 clk,
   input logic                 reset,
   commit_trace_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } entry_t;

   entry_t            r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [LVL_W-1:0]  r_level;
   logic [TS_W-1:0]   r_ts;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic              r_overflow;
   logic              r_conflict;

   logic              w_reg_ev;
   logic              w_mem_ev;
   logic              w_conflict;
   logic              w_pop;
   logic [LVL_W-1:0]  w_free;
   logic              w_acc_reg;
   logic              w_acc_mem;
   logic [LVL_W-1:0]  w_n_push;
   logic [1:0]        w_n_drop;
   logic [CNT_W:0]    w_drop_sum;
   logic [CNT_W-1:0]  w_drop_next;
   entry_t            w_reg_entry;
   entry_t            w_mem_entry;
   entry_t            w_slot0;
   entry_t            w_head;
   logic [PTR_W-1:0]  w_wptr_p1;

   always_comb begin
      w_reg_ev   = bus.reg_write_sig & bus.cfg_reg_en;
      w_conflict = bus.wr & bus.rd;
      w_mem_ev   = bus.cfg_mem_en & (bus.wr ^ bus.rd);
      w_pop      = (r_level != '0) & bus.out_ready;
      // The slot freed by a same-cycle pop is usable by this cycle's pushes
      w_free     = LVL_W'(DEPTH) - r_level + LVL_W'(w_pop);
      w_acc_reg  = w_reg_ev & (w_free != '0);
      w_acc_mem  = w_mem_ev & (w_free > LVL_W'(w_acc_reg));
      w_n_push   = LVL_W'(w_acc_reg) + LVL_W'(w_acc_mem);
      w_n_drop   = 2'(w_reg_ev & ~w_acc_reg) + 2'(w_mem_ev & ~w_acc_mem);
      w_drop_sum = (CNT_W+1)'(r_drop_cnt) + (CNT_W+1)'(w_n_drop);
      w_drop_next = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

      w_reg_entry.kind = 2'b00;
      w_reg_entry.idx  = ADDR_W'(bus.reg_num);
      w_reg_entry.data = bus.reg_data;
      w_reg_entry.ts   = r_ts;
      w_mem_entry.kind = bus.wr ? 2'b01 : 2'b10;
      w_mem_entry.idx  = bus.addr;
      w_mem_entry.data = bus.wr ? bus.wr_data : bus.rd_data;
      w_mem_entry.ts   = r_ts;

      w_slot0   = w_acc_reg ? w_reg_entry : w_mem_entry;
      w_wptr_p1 = r_wptr + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_ts       <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
         r_conflict <= 1'b0;
      end else if (bus.clear) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_ts       <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_ts       <= r_ts + TS_W'(1);
         r_wptr     <= r_wptr + PTR_W'(w_n_push);
         r_rptr     <= r_rptr + PTR_W'(w_pop);
         r_level    <= r_level + w_n_push - LVL_W'(w_pop);
         r_drop_cnt <= w_drop_next;
         r_overflow <= r_overflow | (w_n_drop != 2'd0);
         r_conflict <= r_conflict | w_conflict;
      end
   end

   // Storage needs no reset: nothing is visible unless level says it is valid
   always_ff @(posedge clk) begin
      if (reset && !bus.clear) begin
         if (w_acc_reg | w_acc_mem) r_mem[r_wptr] <= w_slot0;
         if (w_acc_reg & w_acc_mem) r_mem[w_wptr_p1] <= w_mem_entry;
      end
   end

   assign w_head        = (r_level != '0) ? r_mem[r_rptr] : '0;
   assign bus.out_valid = (r_level != '0);
   assign bus.out_kind  = w_head.kind;
   assign bus.out_idx   = w_head.idx;
   assign bus.out_data  = w_head.data;
   assign bus.out_ts    = w_head.ts;
   assign bus.level     = r_level;
   assign bus.drop_cnt  = r_drop_cnt;
   assign bus.overflow  = r_overflow;
   assign bus.conflict  = r_conflict;
endmodule
